// File: rtl/sim_mon_pkg.sv
// ----------------------------------------------------------------------------
// sim_mon_pkg
//   Shared types and constants for the end-of-test monitor.
//   mon_status_e : monitor verdict, RUN while the test is still in progress.
//   TOHOST_PASS_VAL : tohost value that signals a passing test.
// ----------------------------------------------------------------------------
package sim_mon_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        PASS    = 3'd1,
        FAIL    = 3'd2,
        TIMEOUT = 3'd3,
        STALL   = 3'd4
    } mon_status_e;

    localparam logic [31:0] TOHOST_PASS_VAL = 32'h1;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter. Adds i_inc every clock, sticks at all-ones instead
//   of wrapping. i_clr has priority over the increment.
//   Ports:
//     clk    : clock
//     reset  : asynchronous active-high reset, clears the count
//     i_inc  : amount to add this cycle (0 holds the count)
//     i_clr  : synchronous clear
//     o_cnt  : registered count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum = {1'b0, cnt_q} + {1'b0, i_inc};
        if (i_clr) begin
            cnt_d = '0;
        end else if (sum[W]) begin
            // carry out means the true sum no longer fits: pin at all-ones
            cnt_d = '1;
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/sim_test_monitor.sv
// ----------------------------------------------------------------------------
// sim_test_monitor
//   End-of-test monitor for rv32i_soc regressions. Snoops store ports and
//   retire strobes of NUM_CH channels and decides PASS / FAIL / TIMEOUT /
//   STALL. Once out of RUN the verdict and all counters hold until reset.
//   Ports:
//     clk, reset     : clock, asynchronous active-high reset
//     i_en           : monitor enable; everything frozen while low
//     i_st_valid     : per-channel store beat valid
//     i_st_addr      : per-channel store byte address (ADDR_W each)
//     i_st_wdata     : per-channel store data (32 bits each)
//     i_retire       : per-channel instruction retire strobe
//     o_done/o_pass  : test finished / finished with PASS
//     o_status       : mon_status_e verdict
//     o_fail_code    : tohost[31:1] of a failing write, else 0
//     o_fail_ch      : channel whose tohost write ended the test
//     o_cycle_cnt    : enabled cycles spent in RUN (saturating)
//     o_retire_cnt   : total retired instructions (saturating)
// ----------------------------------------------------------------------------
module sim_test_monitor
    import sim_mon_pkg::*;
#(
    parameter int                NUM_CH         = 1,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int                TIMEOUT_CYCLES = 500000,
    parameter int                STALL_CYCLES   = 1024,
    parameter int                CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic [NUM_CH-1:0]        i_st_valid,
    input  logic [NUM_CH*ADDR_W-1:0] i_st_addr,
    input  logic [NUM_CH*32-1:0]     i_st_wdata,
    input  logic [NUM_CH-1:0]        i_retire,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [2:0]               o_status,
    output logic [30:0]              o_fail_code,
    output logic [2:0]               o_fail_ch,
    output logic [CNT_W-1:0]         o_cycle_cnt,
    output logic [CNT_W-1:0]         o_retire_cnt
);

    // Idle counter only needs to reach STALL_CYCLES; saturation keeps it there.
    localparam int IDLE_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;

    mon_status_e state_q, state_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic [2:0]  fail_ch_q, fail_ch_d;

    logic              active;
    logic [NUM_CH-1:0] hit;
    logic [31:0]       ch_wdata [NUM_CH];
    logic              win_found;
    logic [2:0]        win_ch;
    logic [31:0]       win_data;
    logic [CNT_W-1:0]  ret_pop;
    logic              any_retire;
    logic              timeout_hit;
    logic              stall_hit;

    logic [CNT_W-1:0]  cycle_cnt, retire_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CNT_W-1:0]  cycle_inc, retire_inc;
    logic [IDLE_W-1:0] idle_inc;
    logic              idle_clr;

    assign active     = i_en && (state_q == RUN);
    assign any_retire = |i_retire;

    // A store only counts as a verdict when bit 0 is set; even values are
    // syscalls or clears of tohost.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
        assign ch_wdata[gi] = i_st_wdata[gi*32 +: 32];
        assign hit[gi]      = i_st_valid[gi]
                           && (i_st_addr[gi*ADDR_W +: ADDR_W] == TOHOST_ADDR)
                           && i_st_wdata[gi*32];
    end

    // Lowest channel index wins: scan downward so the last assignment sticks.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        win_data  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win_found = 1'b1;
                win_ch    = 3'(k);
                win_data  = ch_wdata[k];
            end
        end
    end

    always_comb begin
        ret_pop = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ret_pop = ret_pop + CNT_W'(i_retire[k]);
        end
    end

    // Thresholds are checked against the value the counter takes on this edge.
    assign timeout_hit = active && ((64'(cycle_cnt) + 64'd1) == 64'(TIMEOUT_CYCLES));
    assign stall_hit   = active && !any_retire && (STALL_CYCLES != 0)
                      && ((64'(idle_cnt) + 64'd1) == 64'(STALL_CYCLES));

    assign cycle_inc  = active ? CNT_W'(1) : '0;
    assign retire_inc = active ? ret_pop : '0;
    assign idle_inc   = (active && !any_retire) ? IDLE_W'(1) : '0;
    assign idle_clr   = active && any_retire;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (cycle_inc),
        .i_clr (1'b0),
        .o_cnt (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (retire_inc),
        .i_clr (1'b0),
        .o_cnt (retire_cnt)
    );

    sat_counter #(.W(IDLE_W)) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (idle_inc),
        .i_clr (idle_clr),
        .o_cnt (idle_cnt)
    );

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        fail_ch_d   = fail_ch_q;
        if (active) begin
            if (win_found) begin
                fail_ch_d = win_ch;
                if (win_data == TOHOST_PASS_VAL) begin
                    state_d = PASS;
                end else begin
                    state_d     = FAIL;
                    fail_code_d = win_data[31:1];
                end
            end else if (timeout_hit) begin
                state_d   = TIMEOUT;
                fail_ch_d = '0;
            end else if (stall_hit) begin
                state_d   = STALL;
                fail_ch_d = '0;
            end
        end
        done_d = (state_d != RUN);
        pass_d = (state_d == PASS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= '0;
            fail_ch_q   <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            fail_ch_q   <= fail_ch_d;
        end
    end

    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_status     = state_q;
    assign o_fail_code  = fail_code_q;
    assign o_fail_ch    = fail_ch_q;
    assign o_cycle_cnt  = cycle_cnt;
    assign o_retire_cnt = retire_cnt;

endmodule

// File: tb/tb_sim_test_monitor.sv
// ----------------------------------------------------------------------------
// tb_sim_test_monitor
//   Directed bench for sim_test_monitor. Four instances share clock, reset
//   and enable: u1/u3 are single-channel (u3 with short timeout/stall limits),
//   u4/u6 are four-channel (u6 with 4-bit counters, stall disabled on both).
// ----------------------------------------------------------------------------
module tb_sim_test_monitor;
    import sim_mon_pkg::*;

    localparam logic [31:0] TH = 32'h8000_1000;

    logic clk = 1'b0;
    logic reset;
    logic en;

    logic [0:0]   a_valid, a_retire;
    logic [31:0]  a_addr, a_wdata;
    logic [3:0]   b_valid, b_retire;
    logic [127:0] b_addr, b_wdata;

    logic        u1_done, u1_pass, u3_done, u3_pass, u4_done, u4_pass, u6_done, u6_pass;
    logic [2:0]  u1_status, u3_status, u4_status, u6_status;
    logic [30:0] u1_code, u3_code, u4_code, u6_code;
    logic [2:0]  u1_ch, u3_ch, u4_ch, u6_ch;
    logic [31:0] u1_cyc, u1_ret, u3_cyc, u3_ret, u4_cyc, u4_ret;
    logic [3:0]  u6_cyc, u6_ret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sim_test_monitor #(.NUM_CH(1)) u1 (
        .clk(clk), .reset(reset), .i_en(en),
        .i_st_valid(a_valid), .i_st_addr(a_addr), .i_st_wdata(a_wdata), .i_retire(a_retire),
        .o_done(u1_done), .o_pass(u1_pass), .o_status(u1_status), .o_fail_code(u1_code),
        .o_fail_ch(u1_ch), .o_cycle_cnt(u1_cyc), .o_retire_cnt(u1_ret)
    );

    sim_test_monitor #(.NUM_CH(1), .TIMEOUT_CYCLES(50), .STALL_CYCLES(16)) u3 (
        .clk(clk), .reset(reset), .i_en(en),
        .i_st_valid(a_valid), .i_st_addr(a_addr), .i_st_wdata(a_wdata), .i_retire(a_retire),
        .o_done(u3_done), .o_pass(u3_pass), .o_status(u3_status), .o_fail_code(u3_code),
        .o_fail_ch(u3_ch), .o_cycle_cnt(u3_cyc), .o_retire_cnt(u3_ret)
    );

    sim_test_monitor #(.NUM_CH(4), .STALL_CYCLES(0)) u4 (
        .clk(clk), .reset(reset), .i_en(en),
        .i_st_valid(b_valid), .i_st_addr(b_addr), .i_st_wdata(b_wdata), .i_retire(b_retire),
        .o_done(u4_done), .o_pass(u4_pass), .o_status(u4_status), .o_fail_code(u4_code),
        .o_fail_ch(u4_ch), .o_cycle_cnt(u4_cyc), .o_retire_cnt(u4_ret)
    );

    sim_test_monitor #(.NUM_CH(4), .STALL_CYCLES(0), .CNT_W(4)) u6 (
        .clk(clk), .reset(reset), .i_en(en),
        .i_st_valid(b_valid), .i_st_addr(b_addr), .i_st_wdata(b_wdata), .i_retire(b_retire),
        .o_done(u6_done), .o_pass(u6_pass), .o_status(u6_status), .o_fail_code(u6_code),
        .o_fail_ch(u6_ch), .o_cycle_cnt(u6_cyc), .o_retire_cnt(u6_ret)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        a_valid  = '0; a_addr = '0; a_wdata = '0; a_retire = '0;
        b_valid  = '0; b_addr = '0; b_wdata = '0; b_retire = '0;
        tick();
        tick();
        chk("rst_status", 64'(u1_status), 64'(RUN));
        chk("rst_done",   64'(u1_done), 64'd0);
        chk("rst_pass",   64'(u1_pass), 64'd0);
        chk("rst_cycle",  64'(u1_cyc), 64'd0);
        chk("rst_retire", 64'(u1_ret), 64'd0);
        chk("rst_code",   64'(u1_code), 64'd0);
        chk("rst_ch",     64'(u1_ch), 64'd0);
        $display("txn reset: status=%0d done=%0d", u1_status, u1_done);

        // 1: PASS at cycle 100
        do_reset();
        en = 1'b1; a_retire = 1'b1;
        repeat (100) tick();
        chk("t1_done_before", 64'(u1_done), 64'd0);
        chk("t1_cycle_before", 64'(u1_cyc), 64'd100);
        a_valid = 1'b1; a_addr = TH; a_wdata = 32'h1;
        tick();
        a_valid = 1'b0;
        chk("t1_done",   64'(u1_done), 64'd1);
        chk("t1_pass",   64'(u1_pass), 64'd1);
        chk("t1_status", 64'(u1_status), 64'(PASS));
        chk("t1_cycle",  64'(u1_cyc), 64'd101);
        chk("t1_retire", 64'(u1_ret), 64'd101);
        repeat (5) tick();
        chk("t1_cycle_frozen", 64'(u1_cyc), 64'd101);
        $display("txn pass@100: status=%0d cycle=%0d", u1_status, u1_cyc);

        // 2: ignored writes, then FAIL with code 21, later PASS write ignored
        do_reset();
        en = 1'b1; a_retire = 1'b1;
        repeat (5) tick();
        a_valid = 1'b1; a_addr = TH; a_wdata = 32'h0;
        tick();
        chk("t2_zero_ignored", 64'(u1_status), 64'(RUN));
        a_wdata = 32'h2;
        tick();
        chk("t2_even_ignored", 64'(u1_status), 64'(RUN));
        a_addr = TH + 32'd4; a_wdata = 32'h1;
        tick();
        chk("t2_addr_ignored", 64'(u1_status), 64'(RUN));
        a_addr = TH; a_wdata = 32'h0000_002B;
        tick();
        chk("t2_status", 64'(u1_status), 64'(FAIL));
        chk("t2_code",   64'(u1_code), 64'd21);
        chk("t2_pass",   64'(u1_pass), 64'd0);
        chk("t2_done",   64'(u1_done), 64'd1);
        chk("t2_cycle",  64'(u1_cyc), 64'd9);
        a_wdata = 32'h1;
        tick();
        a_valid = 1'b0;
        chk("t2_sticky_status", 64'(u1_status), 64'(FAIL));
        chk("t2_sticky_code",   64'(u1_code), 64'd21);
        $display("txn fail 0x2b: status=%0d code=%0d", u1_status, u1_code);

        // 3: TIMEOUT at 50, then PASS on the same edge wins
        do_reset();
        en = 1'b1; a_retire = 1'b1;
        repeat (49) tick();
        chk("t3_run_49",   64'(u3_status), 64'(RUN));
        chk("t3_cycle_49", 64'(u3_cyc), 64'd49);
        tick();
        chk("t3_timeout", 64'(u3_status), 64'(TIMEOUT));
        chk("t3_cycle",   64'(u3_cyc), 64'd50);
        chk("t3_done",    64'(u3_done), 64'd1);
        chk("t3_pass",    64'(u3_pass), 64'd0);
        chk("t3_ch",      64'(u3_ch), 64'd0);
        tick();
        chk("t3_cycle_frozen", 64'(u3_cyc), 64'd50);
        $display("txn timeout: status=%0d cycle=%0d", u3_status, u3_cyc);
        do_reset();
        repeat (49) tick();
        a_valid = 1'b1; a_addr = TH; a_wdata = 32'h1;
        tick();
        a_valid = 1'b0;
        chk("t3_pass_wins", 64'(u3_status), 64'(PASS));
        chk("t3_pass_cycle", 64'(u3_cyc), 64'd50);
        $display("txn pass vs timeout: status=%0d", u3_status);

        // 5: STALL after 16 idle cycles, retire at idle 15 restarts the count
        do_reset();
        en = 1'b1; a_retire = 1'b0;
        repeat (15) tick();
        chk("t5_run_idle15", 64'(u3_status), 64'(RUN));
        a_retire = 1'b1;
        tick();
        a_retire = 1'b0;
        repeat (15) tick();
        chk("t5_run_after_retire", 64'(u3_status), 64'(RUN));
        tick();
        chk("t5_stall",  64'(u3_status), 64'(STALL));
        chk("t5_cycle",  64'(u3_cyc), 64'd32);
        chk("t5_retire", 64'(u3_ret), 64'd1);
        chk("t5_ch",     64'(u3_ch), 64'd0);
        $display("txn stall: status=%0d cycle=%0d", u3_status, u3_cyc);

        // 5b: enable low freezes everything
        do_reset();
        en = 1'b1; a_retire = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        a_valid = 1'b1; a_addr = TH; a_wdata = 32'h1;
        repeat (20) tick();
        chk("t5_en_cycle",  64'(u3_cyc), 64'd5);
        chk("t5_en_retire", 64'(u3_ret), 64'd5);
        chk("t5_en_status", 64'(u3_status), 64'(RUN));
        a_valid = 1'b0; en = 1'b1;
        tick();
        chk("t5_en_resume", 64'(u3_cyc), 64'd6);
        $display("txn enable hold: cycle=%0d retire=%0d", u3_cyc, u3_ret);

        // 4/6: four channels, stall disabled, saturation, async reset, priority
        do_reset();
        en = 1'b1; b_retire = 4'b0000;
        repeat (40) tick();
        chk("t4_no_stall", 64'(u4_status), 64'(RUN));
        chk("t4_cycle",    64'(u4_cyc), 64'd40);
        chk("t6_cycle_sat", 64'(u6_cyc), 64'd15);
        b_retire = 4'b1011;
        repeat (10) tick();
        b_retire = 4'b0000;
        chk("t4_retire",    64'(u4_ret), 64'd30);
        chk("t6_retire_sat", 64'(u6_ret), 64'd15);
        $display("txn retire 1011x10: u4=%0d u6=%0d", u4_ret, u6_ret);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_retire", 64'(u6_ret), 64'd0);
        chk("t6_async_cycle",  64'(u6_cyc), 64'd0);
        chk("t6_async_status", 64'(u6_status), 64'(RUN));
        chk("t6_async_u4ret",  64'(u4_ret), 64'd0);
        tick();
        reset = 1'b0;
        $display("txn async reset: u6 retire=%0d cycle=%0d", u6_ret, u6_cyc);
        b_valid = 4'b0110;
        b_addr  = {TH, TH, TH, TH};
        b_wdata = {32'h0, 32'h1, 32'h3, 32'h0};
        tick();
        b_valid = '0;
        chk("t4_fail",      64'(u4_status), 64'(FAIL));
        chk("t4_fail_ch",   64'(u4_ch), 64'd1);
        chk("t4_fail_code", 64'(u4_code), 64'd1);
        chk("t4_done",      64'(u4_done), 64'd1);
        $display("txn ch1=3 ch2=1: status=%0d ch=%0d code=%0d", u4_status, u4_ch, u4_code);
        do_reset();
        b_valid = 4'b1000;
        b_wdata = {32'h1, 32'h0, 32'h0, 32'h1};
        tick();
        b_valid = '0;
        chk("t4_pass_ch3",  64'(u4_status), 64'(PASS));
        chk("t4_ch3",       64'(u4_ch), 64'd3);
        chk("t4_pass_flag", 64'(u4_pass), 64'd1);
        $display("txn ch3=1: status=%0d ch=%0d", u4_status, u4_ch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
